// File: rtl/rgb_led_sequencer_pkg.sv
// rtl/rgb_led_sequencer_pkg.sv - colour indices and sequencer state encodings
package rgb_led_sequencer_pkg;

  // Colour FSM one-hot bit positions, shared with the colour FSM and its benches
  localparam int stIDLE    = 0;
  localparam int stRED     = 1;
  localparam int stYELLOW  = 2;
  localparam int stGREEN   = 3;
  localparam int stCYAN    = 4;
  localparam int stBLUE    = 5;
  localparam int stMAGENTA = 6;
  localparam int stBLACK   = 7;

  localparam logic [7:0] SNAP_RST = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DWELL    = 3'd1,
    S_PULSE    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_ERROR    = 3'd4
  } seq_state_e;

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/led_dwell_counter.sv
// rtl/led_dwell_counter.sv - dwell down-counter, flags the last dwell clock
module led_dwell_counter #(
  parameter int CNT_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             enable,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] r_count;

  // Holds clocks remaining after the current one; values 0 and 1 both load 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= (value > ONE) ? (value - ONE) : '0;
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/rgb_led_sequencer.sv
// rtl/rgb_led_sequencer.sv - dwell timer and next/ack handshake to the colour FSM
module rgb_led_sequencer #(
  parameter int          CNT_W     = 24,
  parameter int unsigned DWELL_RST = 16000000,
  parameter int          ACK_TO    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             step,
  input  logic             clear,
  input  logic [CNT_W-1:0] dwell,
  input  logic             dwell_load,
  input  logic [7:0]       fsm_state,
  output logic             next,
  output logic             busy,
  output logic             cycle_done,
  output logic             error
);
  import rgb_led_sequencer_pkg::*;

  localparam logic [CNT_W-1:0] DWELL_RST_V = CNT_W'(DWELL_RST);
  localparam logic [7:0]       ACK_LAST    = 8'(ACK_TO - 1);

  seq_state_e       r_state;
  logic [CNT_W-1:0] r_dwell;
  logic [7:0]       r_snap;
  logic [7:0]       r_ack_cnt;
  logic             r_next;
  logic             r_busy;
  logic             r_cycle_done;
  logic             r_error;

  logic [CNT_W-1:0] w_load_value;
  logic             w_changed;
  logic             w_ack;
  logic             w_cnt_load;
  logic             w_cnt_en;
  logic             w_zero;

  // A load coinciding with a reload must take the freshly presented value
  assign w_load_value = dwell_load ? dwell : r_dwell;
  assign w_changed    = (fsm_state != r_snap);
  assign w_ack        = w_changed && is_onehot8(fsm_state);
  assign w_cnt_load   = enable && ((r_state == S_IDLE) ||
                                   ((r_state == S_WAIT_ACK) && w_ack));
  assign w_cnt_en     = (r_state == S_DWELL);

  led_dwell_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .load   (w_cnt_load),
    .value  (w_load_value),
    .enable (w_cnt_en),
    .zero   (w_zero)
  );

  // Dwell register, writable in every state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dwell <= DWELL_RST_V;
    end else if (dwell_load) begin
      r_dwell <= dwell;
    end
  end

  // Sequencer FSM with registered next/busy/cycle_done/error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_snap       <= SNAP_RST;
      r_ack_cnt    <= '0;
      r_next       <= 1'b0;
      r_busy       <= 1'b0;
      r_cycle_done <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_next       <= 1'b0;
      r_cycle_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_DWELL;
            r_busy  <= 1'b1;
          end else if (step) begin
            r_state <= S_PULSE;
            r_next  <= 1'b1;
            r_busy  <= 1'b1;
            r_snap  <= fsm_state;
          end
        end
        S_DWELL: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_zero) begin
            r_state <= S_PULSE;
            r_next  <= 1'b1;
            r_snap  <= fsm_state;
          end
        end
        S_PULSE: begin
          r_state   <= S_WAIT_ACK;
          r_ack_cnt <= 8'd1;
        end
        S_WAIT_ACK: begin
          if (w_ack) begin
            r_cycle_done <= r_snap[stBLACK] && fsm_state[stIDLE];
            if (enable) begin
              r_state <= S_DWELL;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (w_changed || (r_ack_cnt == ACK_LAST)) begin
            r_state <= S_ERROR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else begin
            r_ack_cnt <= r_ack_cnt + 8'd1;
          end
        end
        S_ERROR: begin
          if (clear) begin
            r_state <= S_IDLE;
            r_error <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign next       = r_next;
  assign busy       = r_busy;
  assign cycle_done = r_cycle_done;
  assign error      = r_error;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// tb/tb_rgb_led_sequencer.sv - self-checking bench for rgb_led_sequencer with a colour FSM model
module tb_rgb_led_sequencer;

  localparam int CNT_W     = 24;
  localparam int DWELL_RST = 7;
  localparam int ACK_TO    = 4;

  typedef struct {
    logic [CNT_W-1:0] dwell;
    int               pulses;
    int               period;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [7:0] fsm;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             step;
  logic             clear;
  logic [CNT_W-1:0] dwell;
  logic             dwell_load;
  logic [7:0]       fsm_state;
  logic             next;
  logic             busy;
  logic             cycle_done;
  logic             error;

  logic [1:0] mode;
  logic [7:0] col_q;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  int         col = 0;
  int         n_wraps = 0;
  int         exp_wraps = 0;
  exp_t       exp_q[$];
  exp_t       mon_e;
  vec_t       vecs[5];

  rgb_led_sequencer #(
    .CNT_W     (CNT_W),
    .DWELL_RST (DWELL_RST),
    .ACK_TO    (ACK_TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .step       (step),
    .clear      (clear),
    .dwell      (dwell),
    .dwell_load (dwell_load),
    .fsm_state  (fsm_state),
    .next       (next),
    .busy       (busy),
    .cycle_done (cycle_done),
    .error      (error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Colour FSM model: 0 rotates on next, 1 holds (disconnected), 2 corrupts to non-one-hot
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q <= 8'h01;
    end else if (next) begin
      case (mode)
        2'd0:    col_q <= {col_q[6:0], col_q[7]};
        2'd2:    col_q <= 8'h03;
        default: col_q <= col_q;
      endcase
    end
  end

  assign fsm_state = col_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every next pulse must match a queued expectation
  always @(negedge clock) begin
    if (reset && next) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_next: got pulse expected none (cyc %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("next_cycle", cyc, mon_e.cyc);
        check("fsm_at_next", {24'h0, fsm_state}, {24'h0, mon_e.fsm});
      end
    end
    if (reset && cycle_done) begin
      n_wraps++;
      check("fsm_at_cycle_done", {24'h0, fsm_state}, 32'h01);
    end
  end

  task automatic wait_sb(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
    end
    check("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic push_exp(input int c);
    exp_t e;
    e.cyc = c;
    e.fsm = 8'h01 << col;
    exp_q.push_back(e);
  endtask

  task automatic advance_col();
    col = (col + 1) % 8;
    if (col == 0) exp_wraps++;
  endtask

  task automatic run_auto(input logic [CNT_W-1:0] d, input bit load, input int period, input int n);
    int c0;
    @(negedge clock);
    if (load) begin
      dwell      = d;
      dwell_load = 1'b1;
    end
    enable = 1'b1;
    c0 = cyc;
    for (int k = 0; k < n; k++) begin
      push_exp(c0 + period - 1 + k * period);
      advance_col();
    end
    @(negedge clock);
    dwell_load = 1'b0;
    wait_sb(n * period + 20);
    enable = 1'b0;
    repeat (4) @(negedge clock);
    check("busy_after_run", busy, 0);
    check("fsm_after_run", {24'h0, fsm_state}, 32'h01 << col);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    col   = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("error_after_clear", error, 0);
    check("busy_after_clear", busy, 0);
  endtask

  initial begin
    int c;
    vecs[0] = '{24'd3, 8, 5};
    vecs[1] = '{24'd0, 3, 3};
    vecs[2] = '{24'd1, 3, 3};
    vecs[3] = '{24'd5, 2, 7};
    vecs[4] = '{24'd2, 5, 4};

    reset = 1'b0; enable = 1'b0; step = 1'b0; clear = 1'b0;
    dwell = '0; dwell_load = 1'b0; mode = 2'd0;
    repeat (2) @(negedge clock);
    check("rst_next", next, 0);
    check("rst_busy", busy, 0);
    check("rst_cycle_done", cycle_done, 0);
    check("rst_error", error, 0);
    check("rst_dwell_reg", dut.r_dwell, DWELL_RST);
    reset = 1'b1;

    // Auto-run rows: dwell loaded on the same edge that starts the dwell
    for (int r = 0; r < 5; r++) run_auto(vecs[r].dwell, 1'b1, vecs[r].period, vecs[r].pulses);
    check("wrap_count", n_wraps, exp_wraps);

    // Three manual steps spaced 10 clocks apart
    do_reset();
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      step = 1'b1;
      push_exp(cyc + 1);
      advance_col();
      @(negedge clock);
      step = 1'b0;
      repeat (8) @(negedge clock);
    end
    wait_sb(5);
    check("step_busy", busy, 0);
    check("step_fsm", {24'h0, fsm_state}, 32'h08);

    // Enable dropped two clocks into the dwell
    @(negedge clock);
    dwell = 24'd5; dwell_load = 1'b1; enable = 1'b1;
    @(negedge clock);
    dwell_load = 1'b0;
    @(negedge clock);
    check("drop_busy_in_dwell", busy, 1);
    enable = 1'b0;
    @(negedge clock);
    check("drop_busy_idle", busy, 0);
    repeat (10) @(negedge clock);
    check("drop_fsm_unchanged", {24'h0, fsm_state}, 32'h08);

    // FSM disconnected: timeout to error; a step in WAIT_ACK is ignored
    @(negedge clock);
    mode = 2'd1; step = 1'b1; c = cyc;
    push_exp(c + 1);
    @(negedge clock);
    step = 1'b0;
    @(negedge clock);
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    repeat (ACK_TO - 3) @(negedge clock);
    check("to_error_early", error, 0);
    check("to_busy_early", busy, 1);
    @(negedge clock);
    check("to_error_set", error, 1);
    check("to_busy_clear", busy, 0);
    check("to_elapsed", cyc - (c + 1), ACK_TO);
    repeat (10) @(negedge clock);
    check("to_error_sticky", error, 1);
    pulse_clear();

    // Non-one-hot change is an error on the first WAIT_ACK edge
    @(negedge clock);
    mode = 2'd2; step = 1'b1;
    push_exp(cyc + 1);
    @(negedge clock);
    step = 1'b0;
    @(negedge clock);
    check("bad_onehot_early", error, 0);
    @(negedge clock);
    check("bad_onehot_error", error, 1);
    pulse_clear();
    mode = 2'd0;
    do_reset();

    // Asynchronous reset in the middle of WAIT_ACK
    @(negedge clock);
    dwell = 24'd9; dwell_load = 1'b1;
    @(negedge clock);
    dwell_load = 1'b0; mode = 2'd1; step = 1'b1;
    push_exp(cyc + 1);
    @(negedge clock);
    step = 1'b0;
    @(negedge clock);
    check("wait_ack_busy", busy, 1);
    check("wait_ack_dwell_reg", dut.r_dwell, 9);
    #2 reset = 1'b0;
    col = 0;
    #1;
    check("async_rst_next", next, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_error", error, 0);
    check("async_rst_dwell_reg", dut.r_dwell, DWELL_RST);
    @(negedge clock);
    reset = 1'b1; mode = 2'd0;
    exp_q.delete();

    // Reset dwell value governs an unloaded run
    run_auto('0, 1'b0, DWELL_RST + 2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/rgb_led_sequencer.md
RGB_LED_SEQUENCER -- requirements
Module: rgb_led_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- CNT_W, 24, dwell counter width.
- DWELL_RST, 16000000, dwell value after reset (1 s at 16 MHz).
- ACK_TO, 4, clocks allowed for the FSM to change state after a next pulse.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clock, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-low reset.
- enable, in, 1, level; auto-run the colour sequence.
- step, in, 1, single-cycle pulse; advance one state when not running.
- clear, in, 1, single-cycle pulse; clears the error flag.
- dwell, in, CNT_W, dwell value in clocks per colour.
- dwell_load, in, 1, captures dwell into the internal dwell register.
- fsm_state, in, 8, one-hot state from the colour FSM (bit0 IDLE ... bit7 BLACK).
- next, out, 1, one-clock advance pulse to the colour FSM.
- busy, out, 1, high in any state other than S_IDLE and S_ERROR.
- cycle_done, out, 1, one-clock pulse when the FSM wraps from BLACK to IDLE.
- error, out, 1, sticky fault flag.

Function
REQ-003 The controller SHALL implement the states S_IDLE, S_DWELL, S_PULSE, S_WAIT_ACK and S_ERROR.
REQ-004 In S_IDLE, enable=1 SHALL move the controller to S_DWELL and load the counter with the dwell register.
REQ-005 In S_IDLE with enable=0, step=1 SHALL move the controller directly to S_PULSE, with no dwell.
REQ-006 step SHALL be ignored while enable=1 or while the state is not S_IDLE.
REQ-007 In S_DWELL, the counter SHALL decrement once per clock; when it reaches 1, the controller SHALL go to S_PULSE, so next rises exactly dwell clocks after S_DWELL is entered.
REQ-008 A dwell register value of 0 SHALL behave as 1.
REQ-009 In S_DWELL, enable=0 SHALL return the controller to S_IDLE on the next edge, with no next pulse.
REQ-010 In S_PULSE, next SHALL be 1 for exactly one clock.
REQ-011 On entering S_PULSE, fsm_state SHALL be snapshotted; the controller then goes to S_WAIT_ACK.
REQ-012 In S_WAIT_ACK, the acknowledge SHALL be fsm_state != snapshot with fsm_state one-hot.
- On acknowledge: go to S_DWELL (reload counter) if enable=1, else to S_IDLE.
- A changed but non-one-hot fsm_state, or no change within ACK_TO clocks: go to S_ERROR with error=1.
REQ-013 If enable falls during S_PULSE or S_WAIT_ACK, the handshake SHALL complete before the controller returns to S_IDLE.
REQ-014 cycle_done SHALL pulse for one clock on the acknowledge edge when snapshot[7]=1 and fsm_state[0]=1.
REQ-015 In S_ERROR, next SHALL be 0 and busy SHALL be 0; clear=1 SHALL set error=0 and go to S_IDLE, and clear SHALL have no effect in any other state.
REQ-016 dwell_load SHALL update the dwell register in any state.
- A load does not affect a count already in progress.
- A load on the same edge as a reload SHALL use the new value.
REQ-017 All outputs SHALL be driven from registers.

Reset
REQ-018 reset=0 SHALL asynchronously force the following, regardless of the current state:
- S_IDLE, counter=0, dwell register=DWELL_RST, snapshot=8'h01.
- next=0, busy=0, cycle_done=0, error=0.
REQ-019 After reset deasserts, the first transition SHALL occur no earlier than the first rising clock edge with reset=1.

Structure
REQ-020 A shared package/include SHALL hold the colour state indices (stIDLE=0 ... stBLACK=7) and the sequencer state encodings, shared with the colour FSM and its benches.
REQ-021 The dwell down-counter MAY be a sub-module named led_dwell_counter (inputs load, value, enable; output zero); everything else SHALL be in one module.

Verification
REQ-022 Each bench scenario below SHALL be covered, with rgb_led_sequencer connected to the colour FSM:
- Reset, dwell_load=1 with dwell=3, then enable=1: next pulses every 3 + handshake clocks; fsm_state walks IDLE->RED->...->BLACK->IDLE; cycle_done=1 exactly once per wrap.
- enable=0, three step pulses spaced 10 clocks apart: exactly three next pulses, fsm_state=8'h08 (GREEN), busy=0 at the end.
- dwell=5, enable=1, enable dropped 2 clocks into S_DWELL: no next pulse, back in S_IDLE next clock, fsm_state unchanged.
- fsm_state held constant (FSM disconnected), step pulse: error=1 ACK_TO clocks after next, no further next pulses; clear returns to S_IDLE with error=0.
- reset=0 asserted mid-S_WAIT_ACK between clock edges: next, busy and error are 0 immediately; the dwell register reads back DWELL_RST.
- dwell=0 loaded with enable=1: behaves identically to dwell=1 (next pulse 1 clock after S_DWELL entry).
